// File: rtl/clock_pkg.sv
`timescale 1ns/1ps
// Shared constants, set-FSM encoding and BCD helpers for the time keeper.
package clock_pkg;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CHECK = 1'b1
  } set_state_e;

  // Increment a two-digit BCD value; the low digit rolls 9 -> 0 with carry.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Both nibbles are decimal digits.
  function automatic logic is_bcd(input logic [7:0] v);
    is_bcd = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_time_keeper_if.sv
`timescale 1ns/1ps
// Set port of the time keeper.
// Handshake: a transfer happens on a rising clock edge where set_valid and
// set_ready are both 1; the master holds set_valid and the payload stable
// until that edge, and set_ready never depends combinationally on set_valid.
interface bcd_time_keeper_if;
  logic       set_valid;
  logic       set_ready;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic       set_pm;
  logic       set_err;

  modport master (output set_valid, set_hh, set_mm, set_ss, set_pm,
                  input  set_ready, set_err);
  modport slave  (input  set_valid, set_hh, set_mm, set_ss, set_pm,
                  output set_ready, set_err);
endinterface

// File: rtl/bcd2_counter.sv
`timescale 1ns/1ps
// Two-digit BCD register that wraps MAX -> MIN; load has priority over inc.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MIN = BCD_00,
  parameter logic [7:0] MAX = BCD_59,
  parameter logic [7:0] RST = BCD_00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       carry_out
);

  logic [7:0] q_q, q_d;

  // Next value: load wins, otherwise step or wrap.
  always_comb begin
    q_d = q_q;
    if (load)     q_d = load_val;
    else if (inc) q_d = (q_q == MAX) ? MIN : bcd_inc(q_q);
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= RST;
    else       q_q <= q_d;
  end

  assign q         = q_q;
  assign carry_out = inc && (q_q == MAX);

endmodule

// File: rtl/bcd_time_keeper.sv
`timescale 1ns/1ps
// Time-of-day keeper: synchronises the 1 Hz input into a one-cycle tick,
// advances a cascaded BCD hh:mm:ss counter and accepts validated set requests.
module bcd_time_keeper
  import clock_pkg::*;
#(
  parameter bit HOUR_24     = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_50Mhz,
  input  logic               reset,
  input  logic               clk_1hz,
  input  logic               run_en,
  bcd_time_keeper_if.slave   set_port,
  output logic [7:0]         hh,
  output logic [7:0]         mm,
  output logic [7:0]         ss,
  output logic               pm,
  output logic               sec_tick,
  output logic               day_wrap,
  output set_state_e         set_state_dbg
);

  localparam logic [7:0] HH_MIN = HOUR_24 ? BCD_00 : BCD_01;
  localparam logic [7:0] HH_MAX = HOUR_24 ? BCD_23 : BCD_12;
  localparam logic [7:0] HH_RST = HOUR_24 ? BCD_00 : BCD_12;

  // fill_q tracks which synchroniser stages hold a real sample; the first
  // real sample only primes the history flop so a high input at reset
  // release never looks like a rising edge.
  logic [SYNC_STAGES-1:0] sync_q, sync_d, fill_q, fill_d;
  logic hist_q, hist_d, primed_q, primed_d, sec_tick_q, sec_tick_d;
  logic pm_q, pm_d, day_wrap_q, day_wrap_d;
  set_state_e state_q, state_d;
  logic [7:0] cap_hh_q, cap_hh_d, cap_mm_q, cap_mm_d, cap_ss_q, cap_ss_d;
  logic cap_pm_q, cap_pm_d;
  logic set_ready, set_err, load_en, set_ok, inc_tick;
  logic ss_carry, mm_carry, hh_carry;

  // Synchroniser, edge history and tick generation.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], clk_1hz};
    fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
    hist_d     = sync_q[SYNC_STAGES-1];
    primed_d   = primed_q | fill_q[SYNC_STAGES-1];
    sec_tick_d = primed_q & sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Set FSM next state: one capture cycle, one check cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (set_port.set_valid) state_d = S_CHECK;
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Set FSM outputs: ready while idle, verdict during check.
  always_comb begin
    set_ready = 1'b0;
    set_err   = 1'b0;
    load_en   = 1'b0;
    case (state_q)
      S_IDLE:  set_ready = 1'b1;
      S_CHECK: begin
        set_err = ~set_ok;
        load_en = set_ok;
      end
      default: ;
    endcase
  end

  // Capture the payload on the accepting edge.
  always_comb begin
    cap_hh_d = cap_hh_q;
    cap_mm_d = cap_mm_q;
    cap_ss_d = cap_ss_q;
    cap_pm_d = cap_pm_q;
    if (state_q == S_IDLE && set_port.set_valid) begin
      cap_hh_d = set_port.set_hh;
      cap_mm_d = set_port.set_mm;
      cap_ss_d = set_port.set_ss;
      cap_pm_d = set_port.set_pm;
    end
  end

  // Validator: decimal digits, minutes/seconds 00..59, hours in range.
  always_comb begin
    set_ok = is_bcd(cap_hh_q) && is_bcd(cap_mm_q) && is_bcd(cap_ss_q) &&
             (cap_mm_q <= BCD_59) && (cap_ss_q <= BCD_59) &&
             (HOUR_24 ? (cap_hh_q <= BCD_23)
                      : (cap_hh_q >= BCD_01 && cap_hh_q <= BCD_12));
  end

  assign inc_tick = sec_tick_q & run_en;

  bcd2_counter #(.MIN(BCD_00), .MAX(BCD_59), .RST(BCD_00)) u_ss (
    .clk(clk_50Mhz), .reset(reset), .inc(inc_tick), .load(load_en),
    .load_val(cap_ss_q), .q(ss), .carry_out(ss_carry));

  bcd2_counter #(.MIN(BCD_00), .MAX(BCD_59), .RST(BCD_00)) u_mm (
    .clk(clk_50Mhz), .reset(reset), .inc(ss_carry), .load(load_en),
    .load_val(cap_mm_q), .q(mm), .carry_out(mm_carry));

  bcd2_counter #(.MIN(HH_MIN), .MAX(HH_MAX), .RST(HH_RST)) u_hh (
    .clk(clk_50Mhz), .reset(reset), .inc(mm_carry), .load(load_en),
    .load_val(cap_hh_q), .q(hh), .carry_out(hh_carry));

  // pm flag and day-wrap pulse; a load suppresses the concurrent increment.
  always_comb begin
    pm_d       = pm_q;
    day_wrap_d = 1'b0;
    if (load_en) begin
      pm_d = HOUR_24 ? 1'b0 : cap_pm_q;
    end else begin
      if (!HOUR_24 && mm_carry && hh == BCD_11) pm_d = ~pm_q;
      day_wrap_d = HOUR_24 ? hh_carry : (mm_carry && hh == BCD_11 && pm_q);
    end
  end

  // All top-level state registers.
  always_ff @(posedge clk_50Mhz or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      fill_q     <= '0;
      hist_q     <= 1'b0;
      primed_q   <= 1'b0;
      sec_tick_q <= 1'b0;
      state_q    <= S_IDLE;
      cap_hh_q   <= '0;
      cap_mm_q   <= '0;
      cap_ss_q   <= '0;
      cap_pm_q   <= 1'b0;
      pm_q       <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      fill_q     <= fill_d;
      hist_q     <= hist_d;
      primed_q   <= primed_d;
      sec_tick_q <= sec_tick_d;
      state_q    <= state_d;
      cap_hh_q   <= cap_hh_d;
      cap_mm_q   <= cap_mm_d;
      cap_ss_q   <= cap_ss_d;
      cap_pm_q   <= cap_pm_d;
      pm_q       <= pm_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign set_port.set_ready = set_ready;
  assign set_port.set_err   = set_err;
  assign pm                 = pm_q;
  assign sec_tick           = sec_tick_q;
  assign day_wrap           = day_wrap_q;
  assign set_state_dbg      = state_q;

endmodule
